// File: rtl/dist_filter_bcd.sv
// Echo width (us) to cm via restoring divider, moving average, then BCD.
// Optional DIST_ROUND_EN: bias numerator by US_PER_CM/2 for round-half-up.
module dist_filter_bcd #(
  parameter int US_PER_CM = 58,
  parameter int AVG_LOG2  = 2,
  parameter int MAX_CM    = 400
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        meas_valid,
  input  logic [15:0] meas_us,
  input  logic        meas_ov,
  output logic        busy,
  output logic        dist_valid,
  output logic [9:0]  dist_cm,
  output logic [15:0] bcd,
  output logic        over_range
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 10 + AVG_LOG2;

  localparam logic [16:0] DIVC  = 17'(US_PER_CM);
  localparam logic [15:0] MAXQ  = 16'(MAX_CM);
  localparam logic [9:0]  MAXC  = 10'(MAX_CM);
`ifdef DIST_ROUND_EN
  localparam logic [16:0] BIAS  = 17'(US_PER_CM / 2);
`else
  localparam logic [16:0] BIAS  = 17'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_AVG,
    S_BCD,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] num_q, num_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic        ov_q, ov_d;
  logic        clp_q, clp_d;

  logic [DEPTH-1:0][9:0] buf_q, buf_d;
  logic [AVG_LOG2-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic                  primed_q, primed_d;

  logic [9:0]  avg_q, avg_d;
  logic [9:0]  bin_q, bin_d;
  logic [15:0] dd_q, dd_d;

  logic [9:0]  cm_q, cm_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovr_q, ovr_d;

  logic [16:0] num_in;
  logic [16:0] trial;
  logic        take;
  logic        clamp;
  logic [9:0]  sample;
  logic [SW-1:0] sum_upd;
  logic [15:0] dd_adj;
  logic [15:0] dd_shift;

  function automatic logic [15:0] dd_fix(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign num_in   = {1'b0, meas_us} + BIAS;
  assign trial    = {rem_q, num_q[15]};
  assign take     = (trial >= DIVC);
  assign clamp    = ov_q || (quo_q > MAXQ);
  assign sample   = clamp ? MAXC : quo_q[9:0];
  assign sum_upd  = sum_q - SW'(buf_q[ptr_q]) + SW'(sample);
  assign dd_adj   = dd_fix(dd_q);
  assign dd_shift = 16'({dd_adj, bin_q[9]});

  assign busy       = (state_q == S_DIV) || (state_q == S_AVG) ||
                      (state_q == S_BCD);
  assign dist_valid = (state_q == S_DONE);
  assign dist_cm    = cm_q;
  assign bcd        = bcd_q;
  assign over_range = ovr_q;

  // Sequencer: capture, divide, average, convert, publish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (meas_valid) state_d = S_DIV;
      S_DIV:   if (cnt_q == 4'd15) state_d = S_AVG;
      S_AVG:   state_d = S_BCD;
      S_BCD:   if (cnt_q == 4'd9) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state for each phase.
  always_comb begin
    cnt_d    = cnt_q;
    num_d    = num_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    ov_d     = ov_q;
    clp_d    = clp_q;
    buf_d    = buf_q;
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    primed_d = primed_q;
    avg_d    = avg_q;
    bin_d    = bin_q;
    dd_d     = dd_q;
    cm_d     = cm_q;
    bcd_d    = bcd_q;
    ovr_d    = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (meas_valid) begin
          // Bit 16 of the numerator seeds the remainder: with a divisor
          // above 1 its quotient bit is always zero, so 16 steps suffice.
          num_d = num_in[15:0];
          rem_d = {15'd0, num_in[16]};
          quo_d = 16'd0;
          ov_d  = meas_ov;
          cnt_d = 4'd0;
        end
      end
      S_DIV: begin
        rem_d = 16'(take ? (trial - DIVC) : trial);
        quo_d = {quo_q[14:0], take};
        num_d = {num_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      S_AVG: begin
        clp_d = clamp;
        if (!primed_q) begin
          buf_d    = {DEPTH{sample}};
          sum_d    = SW'(sample) << AVG_LOG2;
          primed_d = 1'b1;
        end else begin
          buf_d[ptr_q] = sample;
          sum_d        = sum_upd;
          ptr_d        = ptr_q + AVG_LOG2'(1);
        end
        avg_d = sum_d[SW-1:AVG_LOG2];
        bin_d = sum_d[SW-1:AVG_LOG2];
        dd_d  = 16'd0;
        cnt_d = 4'd0;
      end
      S_BCD: begin
        dd_d  = dd_shift;
        bin_d = {bin_q[8:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          cm_d  = avg_q;
          bcd_d = dd_shift;
          ovr_d = clp_q;
          cnt_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath, average buffer and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q    <= '0;
      num_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      ov_q     <= 1'b0;
      clp_q    <= 1'b0;
      buf_q    <= '0;
      ptr_q    <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
      avg_q    <= '0;
      bin_q    <= '0;
      dd_q     <= '0;
      cm_q     <= '0;
      bcd_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      ov_q     <= ov_d;
      clp_q    <= clp_d;
      buf_q    <= buf_d;
      ptr_q    <= ptr_d;
      sum_q    <= sum_d;
      primed_q <= primed_d;
      avg_q    <= avg_d;
      bin_q    <= bin_d;
      dd_q     <= dd_d;
      cm_q     <= cm_d;
      bcd_q    <= bcd_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_dist_filter_bcd.sv
// Bench for dist_filter_bcd: vector table, corner sequences, random vs model.
// Two instances: default parameters and MAX_CM=1023 / AVG_LOG2=1.
module tb_dist_filter_bcd;

  localparam int UPC   = 58;
  localparam int DEPTH = 4;
  localparam int MAXC  = 400;
`ifdef DIST_ROUND_EN
  localparam int RB = 29;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        mv, ov;
  logic [15:0] us;
  logic        busy, dv, ovr;
  logic [9:0]  cm;
  logic [15:0] bcd;

  logic        mv2, ov2;
  logic [15:0] us2;
  logic        busy2, dv2, ovr2;
  logic [9:0]  cm2;
  logic [15:0] bcd2;

  always #5 clk = ~clk;

  dist_filter_bcd u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .meas_valid (mv),
    .meas_us    (us),
    .meas_ov    (ov),
    .busy       (busy),
    .dist_valid (dv),
    .dist_cm    (cm),
    .bcd        (bcd),
    .over_range (ovr)
  );

  dist_filter_bcd #(.AVG_LOG2(1), .MAX_CM(1023)) u_dut2 (
    .clk        (clk),
    .nrst       (nrst),
    .meas_valid (mv2),
    .meas_us    (us2),
    .meas_ov    (ov2),
    .busy       (busy2),
    .dist_valid (dv2),
    .dist_cm    (cm2),
    .bcd        (bcd2),
    .over_range (ovr2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  // Reference: a queue holding the last DEPTH samples.
  int hist[$];

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic ref_push(input int usv, input bit ovv,
                          output int e_cm, output int e_bcd,
                          output bit e_ovr);
    int raw, s, sum;
    raw   = (usv + RB) / UPC;
    e_ovr = ovv || (raw > MAXC);
    s     = e_ovr ? MAXC : raw;
    if (hist.size() == 0) begin
      repeat (DEPTH) hist.push_back(s);
    end else begin
      void'(hist.pop_front());
      hist.push_back(s);
    end
    sum = 0;
    foreach (hist[i]) sum += hist[i];
    e_cm  = sum / DEPTH;
    e_bcd = to_bcd(e_cm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    mv   = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    hist.delete();
  endtask

  // Send one sample on the default instance; check latency and busy.
  task automatic run(input int usv, input bit ovv);
    bit busy_ok;
    int lat;
    @(negedge clk);
    mv = 1'b1;
    us = 16'(usv);
    ov = ovv;
    @(negedge clk);
    mv = 1'b0;
    busy_ok = (busy === 1'b1) && (dv === 1'b0);
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (dv === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk("latency", lat, 28);
    chk("busy_during_conv", int'(busy_ok), 1);
    if (lat > 0) chk("busy_low_at_valid", int'(busy), 0);
  endtask

  task automatic sample_check(input int usv, input bit ovv,
                              input string tag);
    int e_cm, e_bcd;
    bit e_ovr;
    run(usv, ovv);
    ref_push(usv, ovv, e_cm, e_bcd, e_ovr);
    chk({tag, "_cm"}, int'(cm), e_cm);
    chk({tag, "_bcd"}, int'(bcd), e_bcd);
    chk({tag, "_ovr"}, int'(ovr), int'(e_ovr));
    @(negedge clk);
    chk({tag, "_valid_one_cycle"}, int'(dv), 0);
    chk({tag, "_cm_hold"}, int'(cm), e_cm);
  endtask

  typedef struct {
    bit rst;
    int us;
    bit ov;
    int cm;
    int bcd;
    bit ovr;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int e_cm, e_bcd, cnt, first, second, lat;
    bit e_ovr;

    tbl[0] = '{1, 580,  0, 10,  'h0010, 0};
    tbl[1] = '{0, 1160, 0, 12,  'h0012, 0};
    tbl[2] = '{0, 1740, 0, 17,  'h0017, 0};
    tbl[3] = '{0, 2320, 0, 25,  'h0025, 0};
    tbl[4] = '{1, 1234, 1, 400, 'h0400, 1};
    tbl[5] = '{0, 580,  0, 302, 'h0302, 0};

    nrst = 1'b0;
    mv   = 1'b0;
    us   = '0;
    ov   = 1'b0;
    mv2  = 1'b0;
    us2  = '0;
    ov2  = 1'b0;

    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(dv), 0);
    chk("rst_cm", int'(cm), 0);
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_ovr", int'(ovr), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      run(tbl[i].us, tbl[i].ov);
      ref_push(tbl[i].us, tbl[i].ov, e_cm, e_bcd, e_ovr);
      chk($sformatf("tbl%0d_cm", i), int'(cm), tbl[i].cm);
      chk($sformatf("tbl%0d_bcd", i), int'(bcd), tbl[i].bcd);
      chk($sformatf("tbl%0d_ovr", i), int'(ovr), int'(tbl[i].ovr));
    end

    // Boundaries.
    do_reset();
    run(57, 0);
`ifdef DIST_ROUND_EN
    chk("us57_cm", int'(cm), 1);
`else
    chk("us57_cm", int'(cm), 0);
`endif
    do_reset();
    run(65535, 0);
    chk("us65535_cm", int'(cm), 400);
    chk("us65535_ovr", int'(ovr), 1);
    do_reset();
    run(0, 0);
    chk("us0_cm", int'(cm), 0);
    chk("us0_bcd", int'(bcd), 0);

    // Full-scale instance.
    @(negedge clk);
    mv2 = 1'b1;
    us2 = 16'd59334;
    @(negedge clk);
    mv2 = 1'b0;
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (dv2 === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("max1023_latency", lat, 28);
    chk("max1023_cm", int'(cm2), 1023);
    chk("max1023_bcd", int'(bcd2), 'h1023);
    chk("max1023_ovr", int'(ovr2), 0);

    // meas_valid pulse in the middle of DIV is dropped.
    do_reset();
    @(negedge clk);
    mv = 1'b1;
    us = 16'd1160;
    ov = 1'b0;
    @(negedge clk);
    mv = 1'b0;
    repeat (4) @(negedge clk);
    mv = 1'b1;
    us = 16'd5800;
    @(negedge clk);
    mv = 1'b0;
    cnt = 0;
    first = -1;
    for (int n = 7; n <= 80; n++) begin
      @(negedge clk);
      if (dv === 1'b1) begin
        cnt++;
        if (first < 0) first = n;
      end
    end
    chk("mid_div_pulse_count", cnt, 1);
    chk("mid_div_pulse_lat", first, 28);
    ref_push(1160, 0, e_cm, e_bcd, e_ovr);
    chk("mid_div_cm", int'(cm), e_cm);

    // Reset in the middle of BCD.
    do_reset();
    sample_check(580, 0, "pre_abort");
    @(negedge clk);
    mv = 1'b1;
    us = 16'd2320;
    @(negedge clk);
    mv = 1'b0;
    repeat (21) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(dv), 0);
    chk("abort_cm", int'(cm), 0);
    chk("abort_bcd", int'(bcd), 0);
    chk("abort_ovr", int'(ovr), 0);
    @(negedge clk);
    nrst = 1'b1;
    hist.delete();
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dv === 1'b1) cnt++;
    end
    chk("abort_no_valid", cnt, 0);
    run(1160, 0);
    chk("reprime_cm", int'(cm), 20);
    chk("reprime_bcd", int'(bcd), 'h0020);
    ref_push(1160, 0, e_cm, e_bcd, e_ovr);

    // Back-to-back: meas_valid held high across DONE.
    do_reset();
    @(negedge clk);
    mv = 1'b1;
    us = 16'd580;
    ov = 1'b0;
    first = -1;
    second = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (dv === 1'b1) begin
        if (first < 0) begin
          first = n;
        end else begin
          second = n;
          mv = 1'b0;
          break;
        end
      end
    end
    mv = 1'b0;
    chk("b2b_first", first, 28);
    chk("b2b_gap", second - first, 29);
    chk("b2b_cm", int'(cm), 10);
    cnt = 0;
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      if (dv === 1'b1) cnt++;
    end
    chk("b2b_no_third", cnt, 0);

    // Random stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int r, v;
      bit o;
      r = $urandom_range(0, 7);
      o = (r == 0);
      if (r == 1) v = $urandom_range(23000, 65535);
      else        v = $urandom_range(0, 30000);
      sample_check(v, o, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
